// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the memory-wait FSM state encoding and the ALU operand forward-select codes.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FAULT   = 2'd2
  } state_e;

  localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

  // Forward select for one execute-stage source; MEM beats WB, x0 never forwards.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rd_m,
    input logic             reg_write_m,
    input logic [REG_W-1:0] rd_w,
    input logic             reg_write_w
  );
    logic [FWD_W-1:0] sel;
    sel = FWD_NONE;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_ctrl.
// slave  : controller side (hazard info in, stall/flush/forward controls out).
// master : datapath side (the mirror image).
// Parameter CNT_W sizes the stallCycles performance counter.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic [REG_W-1:0] rs1D, rs2D;
  logic [REG_W-1:0] rs1E, rs2E, rdE;
  logic [REG_W-1:0] rdM, rdW;
  logic             memReadE, regWriteM, regWriteW, pcSrcE;
  logic             memReqM, memReadyM;
  logic             stallF, stallD, flushD, flushE, flushW;
  logic             weEM, weMW;
  logic [FWD_W-1:0] forwardAE, forwardBE;
  logic             memErr;
  logic [CNT_W-1:0] stallCycles;

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  memReadE, regWriteM, regWriteW, pcSrcE, memReqM, memReadyM,
    output stallF, stallD, flushD, flushE, flushW, weEM, weMW,
    output forwardAE, forwardBE, memErr, stallCycles
  );

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output memReadE, regWriteM, regWriteW, pcSrcE, memReqM, memReadyM,
    input  stallF, stallD, flushD, flushE, flushW, weEM, weMW,
    input  forwardAE, forwardBE, memErr, stallCycles
  );
endinterface

// File: rtl/pipeline_ctrl_forward_unit.sv
// forward_unit: purely combinational operand forwarding and load-use detection.
// Ports: register indices from D/E/M/W stages plus write/load flags in;
//        forwardAE/forwardBE operand selects and lwStall out.
module forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdE,
  input  logic [REG_W-1:0] rdM,
  input  logic [REG_W-1:0] rdW,
  input  logic             memReadE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  output logic [FWD_W-1:0] forwardAE,
  output logic [FWD_W-1:0] forwardBE,
  output logic             lwStall
);

  // Operand bypass selects for both ALU inputs.
  always_comb begin
    forwardAE = fwd_sel(rs1E, rdM, regWriteM, rdW, regWriteW);
    forwardBE = fwd_sel(rs2E, rdM, regWriteM, rdW, regWriteW);
  end

  // A load in EX feeding a decode-stage source must wait one cycle.
  always_comb begin
    lwStall = memReadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard controller for a 5-stage pipeline.
// Ports: clk, reset (synchronous, active-high), bus (pipeline_ctrl_if.slave)
//        carrying hazard info in and stall/flush/write-enable/forward controls,
//        memErr and the stallCycles counter out. All control outputs are
//        combinational from FSM state and inputs.
// Parameters: MEM_TIMEOUT (MEMWAIT cycles before fault), CNT_W (counter width).
// Optional: define PIPELINE_CTRL_PERF_EN to build the saturating stall-cycle
//           counter; otherwise stallCycles is tied to zero.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              freeze_c;
  logic              fault_c;
  logic              lw_stall_c;
  logic              stall_f_c;

  forward_unit u_forward_unit (
    .rs1D      (bus.rs1D),
    .rs2D      (bus.rs2D),
    .rs1E      (bus.rs1E),
    .rs2E      (bus.rs2E),
    .rdE       (bus.rdE),
    .rdM       (bus.rdM),
    .rdW       (bus.rdW),
    .memReadE  (bus.memReadE),
    .regWriteM (bus.regWriteM),
    .regWriteW (bus.regWriteW),
    .forwardAE (bus.forwardAE),
    .forwardBE (bus.forwardBE),
    .lwStall   (lw_stall_c)
  );

  // Memory-wait FSM: next state, wait counter and freeze request.
  always_comb begin
    logic [WAIT_W-1:0] wait_inc;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze_c   = 1'b0;
    fault_c    = 1'b0;
    wait_inc   = wait_cnt_q + WAIT_W'(1);
    case (state_q)
      RUN: begin
        if (bus.memReqM && !bus.memReadyM) begin
          freeze_c   = 1'b1;
          state_d    = MEMWAIT;
          wait_cnt_d = '0;
        end
      end
      MEMWAIT: begin
        if (!bus.memReadyM) begin
          freeze_c   = 1'b1;
          wait_cnt_d = wait_inc;
          if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = FAULT;
          end
        end else begin
          // Acknowledge arrives: the pipeline advances this same cycle.
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      FAULT: begin
        freeze_c = 1'b1;
        fault_c  = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stage controls: reset > memory freeze > taken branch > load-use stall.
  always_comb begin
    stall_f_c  = 1'b0;
    bus.stallD = 1'b0;
    bus.flushD = 1'b0;
    bus.flushE = 1'b0;
    bus.flushW = 1'b0;
    bus.weEM   = 1'b1;
    bus.weMW   = 1'b1;
    bus.memErr = 1'b0;
    if (reset) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
      bus.flushW = 1'b1;
      bus.weEM   = 1'b0;
      bus.weMW   = 1'b0;
    end else if (freeze_c) begin
      // Whole pipe holds; WB is bubbled so a retiring write is not repeated.
      stall_f_c  = 1'b1;
      bus.stallD = 1'b1;
      bus.flushW = 1'b1;
      bus.weEM   = 1'b0;
      bus.weMW   = 1'b0;
      bus.memErr = fault_c;
    end else if (bus.pcSrcE) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
    end else if (lw_stall_c) begin
      stall_f_c  = 1'b1;
      bus.stallD = 1'b1;
      bus.flushE = 1'b1;
    end
    bus.stallF = stall_f_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles with fetch stalled.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_f_c && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stallCycles = stall_cycles_q;
`else
  assign bus.stallCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a queued expectation per cycle.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 32;

  typedef struct packed {
    logic [11:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  int            m_state;
  int            m_cnt;
  logic [CW-1:0] m_perf;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (bus.regWriteM && bus.rdM != 5'd0 && bus.rdM == rs) return 2'b10;
    if (bus.regWriteW && bus.rdW != 5'd0 && bus.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    bus.rs1D = 5'd0; bus.rs2D = 5'd0; bus.rs1E = 5'd0; bus.rs2E = 5'd0;
    bus.rdE = 5'd0; bus.rdM = 5'd0; bus.rdW = 5'd0;
    bus.memReadE = 1'b0; bus.regWriteM = 1'b0; bus.regWriteW = 1'b0;
    bus.pcSrcE = 1'b0; bus.memReqM = 1'b0; bus.memReadyM = 1'b0;
  endtask

  // One clock: build expectation from the model, check DUT, advance model.
  task automatic cyc(input string tag);
    exp_t        e;
    exp_t        x;
    logic        frz, merr, lw, sf, sd, fd, fe, fw, we;
    logic [1:0]  fa, fb;
    logic [11:0] obs;
    int          ns, nc;
    fa = ref_fwd(bus.rs1E);
    fb = ref_fwd(bus.rs2E);
    lw = bus.memReadE && bus.rdE != 5'd0 && (bus.rdE == bus.rs1D || bus.rdE == bus.rs2D);
    frz = 1'b0; merr = 1'b0; ns = m_state; nc = m_cnt;
    if (m_state == 0) begin
      if (bus.memReqM && !bus.memReadyM) begin frz = 1'b1; ns = 1; nc = 0; end
    end else if (m_state == 1) begin
      if (!bus.memReadyM) begin
        frz = 1'b1; nc = m_cnt + 1;
        if (nc == int'(TO)) ns = 2;
      end else begin
        ns = 0; nc = 0;
      end
    end else begin
      frz = 1'b1; merr = 1'b1;
    end
    sf = 0; sd = 0; fd = 0; fe = 0; fw = 0; we = 1;
    if (reset) begin
      fd = 1; fe = 1; fw = 1; we = 0; merr = 0;
    end else if (frz) begin
      sf = 1; sd = 1; fw = 1; we = 0;
    end else if (bus.pcSrcE) begin
      fd = 1; fe = 1;
    end else if (lw) begin
      sf = 1; sd = 1; fe = 1;
    end
    e.ctl = {sf, sd, fd, fe, fw, we, we, fa, fb, merr};
`ifdef PIPELINE_CTRL_PERF_EN
    e.cnt = m_perf;
`else
    e.cnt = '0;
`endif
    sb.push_back(e);
    #2;
    x = sb.pop_front();
    obs = {bus.stallF, bus.stallD, bus.flushD, bus.flushE, bus.flushW,
           bus.weEM, bus.weMW, bus.forwardAE, bus.forwardBE, bus.memErr};
    checks++;
    assert (obs === x.ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, x.ctl);
    end
    checks++;
    assert (bus.stallCycles === x.cnt) else begin
      failures++;
      $error("FAIL %s stallCycles observed=%0d expected=%0d", tag, bus.stallCycles, x.cnt);
    end
    if (reset) begin
      m_perf = '0; ns = 0; nc = 0;
    end else if (sf && m_perf != '1) begin
      m_perf = m_perf + 1'b1;
    end
    @(posedge clk);
    m_state = ns;
    m_cnt   = nc;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_state = 0; m_cnt = 0; m_perf = '0;
    reset = 1'b1;
    clr();
    @(negedge clk);
    cyc("reset0");
    cyc("reset1");
    reset = 1'b0;
    cyc("idle");

    // Forwarding priority and register-0 exclusion.
    bus.rdM = 5'd5; bus.regWriteM = 1'b1; bus.rdW = 5'd5; bus.regWriteW = 1'b1; bus.rs1E = 5'd5;
    cyc("fwd_mem");
    bus.rdM = 5'd0;
    cyc("fwd_wb");
    bus.rs1E = 5'd0;
    cyc("fwd_x0");
    bus.rdM = 5'd9; bus.rdW = 5'd3; bus.rs1E = 5'd3; bus.rs2E = 5'd9;
    cyc("fwd_mix");
    bus.regWriteM = 1'b0;
    cyc("fwd_nowr");
    clr();

    // Load-use stall, then branch overriding it, then x0 load.
    bus.memReadE = 1'b1; bus.rdE = 5'd7; bus.rs2D = 5'd7;
    cyc("lw_stall");
    bus.pcSrcE = 1'b1;
    cyc("lw_branch");
    bus.pcSrcE = 1'b0; bus.rdE = 5'd0; bus.rs2D = 5'd0;
    cyc("lw_x0");
    clr();

    // Memory wait released by ready; branch pending during freeze.
    bus.memReqM = 1'b1; bus.pcSrcE = 1'b1;
    cyc("mw_entry");
    for (int i = 0; i < 3; i++) cyc("mw_wait");
    bus.memReadyM = 1'b1;
    cyc("mw_release");
    bus.memReqM = 1'b0; bus.pcSrcE = 1'b0;
    cyc("mw_run");
    clr();

    // Load-use stall counter from a clean reset.
    reset = 1'b1;
    cyc("perf_rst");
    reset = 1'b0;
    bus.memReadE = 1'b1; bus.rdE = 5'd7; bus.rs1D = 5'd7;
    for (int i = 0; i < 10; i++) cyc("perf_lw");
    clr();
    cyc("perf_after");

    // Timeout into FAULT, sticky until reset.
    bus.memReqM = 1'b1;
    for (int i = 0; i < 8; i++) cyc("fault_seq");
    bus.memReqM = 1'b0; bus.memReadyM = 1'b1;
    cyc("fault_hold");
    cyc("fault_hold2");
    reset = 1'b1;
    cyc("fault_rst");
    reset = 1'b0;
    clr();
    cyc("fault_clear");

    // Reset during MEMWAIT abandons the wait.
    bus.memReqM = 1'b1;
    cyc("mwr_entry");
    cyc("mwr_wait");
    reset = 1'b1;
    cyc("mwr_rst");
    reset = 1'b0;
    clr();
    cyc("mwr_run");
    bus.memReqM = 1'b1; bus.memReadyM = 1'b1;
    cyc("mwr_hit");
    clr();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
